// File: rtl/z80_snoop_pkg.sv
// Shared types and constants for the Z80 I/O write snooper.
// Build macro Z80_SNOOP_TSTAMP_EN adds a 16-bit timestamp field to every queued entry.
package z80_snoop_pkg;

  localparam int BUSY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE,
    HOLDOFF,
    REQ,
    WAIT_BUSY,
    WAIT_DONE
  } refresh_state_t;

  typedef struct packed {
`ifdef Z80_SNOOP_TSTAMP_EN
    logic [15:0] tstamp;
`endif
    logic [7:0]  addr;
    logic [7:0]  data;
  } snoop_entry_t;

  localparam int ENTRY_W = $bits(snoop_entry_t);

endpackage

// File: rtl/snoop_fifo.sv
// snoop_fifo: generic single-clock show-ahead FIFO with occupancy output.
// The head word is presented combinationally; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module snoop_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             pop_ok;
  logic             push_ok;

  assign valid    = (count != '0);
  assign full     = (count == LW'(DEPTH));
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign pop_ok   = pop & valid;
  assign push_ok  = push & (~full | pop_ok);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/z80_io_snoop.sv
// z80_io_snoop: watches Z80 I/O write cycles, queues matching (port, data) pairs and
// schedules coalesced one-cycle refresh pulses towards the OLED controller.
// Build macro Z80_SNOOP_TSTAMP_EN adds the rd_tstamp port and a free-running cycle counter.
module z80_io_snoop
  import z80_snoop_pkg::*;
#(
  parameter logic [7:0] PORT_BASE       = 8'h10,
  parameter logic [7:0] PORT_MASK       = 8'hF0,
  parameter int         FIFO_DEPTH      = 8,
  parameter int         SYNC_STAGES     = 2,
  parameter int         REFRESH_HOLDOFF = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          iorq_n,
  input  logic                          wr_n,
  input  logic                          m1_n,
  input  logic [7:0]                    addr,
  input  logic [7:0]                    data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_addr,
  output logic [7:0]                    rd_data,
`ifdef Z80_SNOOP_TSTAMP_EN
  output logic [15:0]                   rd_tstamp,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          refresh,
  input  logic                          busy
);

  localparam int HW = (REFRESH_HOLDOFF > 2) ? $clog2(REFRESH_HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(REFRESH_HOLDOFF - 1);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] iorq_sync;
  logic [SYNC_STAGES-1:0] m1_sync;
  logic [7:0]             addr_sync [SYNC_STAGES];
  logic [7:0]             data_sync [SYNC_STAGES];

  logic       wr_s;
  logic       iorq_s;
  logic       m1_s;
  logic [7:0] addr_s;
  logic [7:0] data_s;
  logic       wr_prev;
  logic       io_write;
  logic       port_match;

  snoop_entry_t        cap_entry;
  logic                cap_valid;
  logic [ENTRY_W-1:0]  head_bits;
  snoop_entry_t        head;
  logic                full;
  logic                pop;

  refresh_state_t state;
  logic           dirty;
  logic [HW-1:0]  hold_cnt;
  logic [TW-1:0]  tmo_cnt;

`ifdef Z80_SNOOP_TSTAMP_EN
  logic [15:0] tstamp_cnt;
`endif

  assign wr_s   = wr_sync[SYNC_STAGES-1];
  assign iorq_s = iorq_sync[SYNC_STAGES-1];
  assign m1_s   = m1_sync[SYNC_STAGES-1];
  assign addr_s = addr_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // The falling edge of the synchronized WR strobe marks exactly one write per pulse;
  // M1 low together with IORQ is an interrupt acknowledge and never counts.
  assign io_write   = wr_prev & ~wr_s & ~iorq_s & m1_s;
  assign port_match = ((addr_s & PORT_MASK) == (PORT_BASE & PORT_MASK));

  // Bring every asynchronous bus input into the clk domain; reset parks the chains at bus-idle ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sync   <= '1;
      iorq_sync <= '1;
      m1_sync   <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= '1;
        data_sync[i] <= '1;
      end
    end else begin
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], wr_n};
      iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], iorq_n};
      m1_sync   <= {m1_sync[SYNC_STAGES-2:0], m1_n};
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        addr_sync[i] <= addr_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      addr_sync[0] <= addr;
      data_sync[0] <= data;
    end
  end

`ifdef Z80_SNOOP_TSTAMP_EN
  // Free-running cycle counter used to stamp each detected write.
  always_ff @(posedge clk) begin
    if (!rst_n) tstamp_cnt <= '0;
    else        tstamp_cnt <= tstamp_cnt + 1'b1;
  end
`endif

  // Register the detected write together with the address/data seen on the detection cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_prev   <= 1'b1;
      cap_valid <= 1'b0;
      cap_entry <= '0;
    end else begin
      wr_prev        <= wr_s;
      cap_valid      <= io_write & port_match;
      cap_entry.addr <= addr_s;
      cap_entry.data <= data_s;
`ifdef Z80_SNOOP_TSTAMP_EN
      cap_entry.tstamp <= tstamp_cnt;
`endif
    end
  end

  assign pop = rd_valid & rd_ready;

  snoop_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_valid),
    .push_data (cap_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .valid     (rd_valid),
    .full      (full),
    .level     (level)
  );

  assign head    = snoop_entry_t'(head_bits);
  assign rd_addr = head.addr;
  assign rd_data = head.data;
`ifdef Z80_SNOOP_TSTAMP_EN
  assign rd_tstamp = head.tstamp;
`endif

  // Sticky flag for a matched write that found the queue full with nothing leaving.
  always_ff @(posedge clk) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (cap_valid & full & ~pop)    overflow <= 1'b1;
  end

  // Refresh scheduler: coalesce writes for a fixed holdoff, request once the controller is free,
  // then track its busy handshake so only one refresh is ever outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dirty    <= 1'b0;
      hold_cnt <= '0;
      tmo_cnt  <= '0;
      refresh  <= 1'b0;
    end else begin
      refresh <= 1'b0;
      if (cap_valid)                    dirty <= 1'b1;
      else if (state == REQ && !busy)   dirty <= 1'b0;
      case (state)
        IDLE: begin
          if (dirty) begin
            state    <= HOLDOFF;
            hold_cnt <= '0;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) state    <= REQ;
          else                       hold_cnt <= hold_cnt + 1'b1;
        end
        REQ: begin
          if (!busy) begin
            refresh <= 1'b1;
            tmo_cnt <= '0;
            state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (busy)                    state   <= WAIT_DONE;
          else if (tmo_cnt == TMO_LAST) state  <= IDLE;
          else                         tmo_cnt <= tmo_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_snoop.sv
// Self-checking bench for z80_io_snoop: directed Z80 bus cycles, expected FIFO entries
// queued at issue time and compared by an independent pop monitor.
`timescale 1ns/1ps
module tb_z80_io_snoop;

  localparam int HOLD = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iorq_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       m1_n = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       busy = 1'b0;

  logic       rd_valid;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] level;
  logic       overflow;
  logic       refresh;
`ifdef Z80_SNOOP_TSTAMP_EN
  logic [15:0] rd_tstamp;
`endif

  z80_io_snoop #(
    .PORT_BASE       (8'h10),
    .PORT_MASK       (8'hF0),
    .FIFO_DEPTH      (8),
    .SYNC_STAGES     (2),
    .REFRESH_HOLDOFF (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iorq_n    (iorq_n),
    .wr_n      (wr_n),
    .m1_n      (m1_n),
    .addr      (addr),
    .data      (data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`ifdef Z80_SNOOP_TSTAMP_EN
    .rd_tstamp (rd_tstamp),
`endif
    .level     (level),
    .overflow  (overflow),
    .refresh   (refresh),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  int          refresh_cnt = 0;
  int          last_refresh_cyc = -1;
  int          valid_rise_cyc = -1;
  logic        prev_refresh = 1'b0;
  logic        prev_valid = 1'b0;
  bit          busy_model_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every handshake pops one expected entry; also tracks refresh pulses.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pop: got %0h, expected no entry", {rd_addr, rd_data});
      end else begin
        checkOutput("pop_entry", {16'h0, rd_addr, rd_data}, {16'h0, exp_q.pop_front()});
      end
    end
    if (rd_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = rd_valid;
    if (refresh) begin
      refresh_cnt++;
      last_refresh_cyc = cyc;
      checkOutput("refresh_one_cycle", {31'h0, prev_refresh}, 32'h0);
    end
    prev_refresh = refresh;
  end

  // OledCtrl stand-in: after each refresh pulse, hold busy high for 50 clk.
  initial forever begin
    @(negedge clk);
    if (busy_model_en && refresh) begin
      @(posedge clk); #1 busy = 1'b1;
      repeat (50) @(posedge clk);
      #1 busy = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One Z80 bus cycle; fall_cyc is the cycle count at which WR_n went low at the pin.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic iorq_lvl,
                               input logic m1_lvl, input int low_cyc, output int fall_cyc);
    @(posedge clk); #1;
    addr = a; data = d; iorq_n = iorq_lvl; m1_n = m1_lvl;
    @(posedge clk); #1;
    wr_n = 1'b0;
    fall_cyc = cyc;
    repeat (low_cyc) @(posedge clk);
    #1 wr_n = 1'b1;
    @(posedge clk); #1;
    iorq_n = 1'b1; m1_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic waitRefresh(input int start_cnt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (refresh_cnt > start_cnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  fc;
    int  fc2;
    int  snap;
    int  fall;
    bit  ok;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    checkOutput("reset_level", {28'h0, level}, 32'h0);
    checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("reset_refresh", {31'h0, refresh}, 32'h0);

    // Single matched write, WR low 8 clk: one entry, latency 4, refresh after holdoff
    $display("[TB] single matched write");
    snap = refresh_cnt;
    exp_q.push_back(16'h12A5);
    applyStimulus(8'h12, 8'hA5, 1'b0, 1'b1, 8, fc);
    checkOutput("valid_latency", valid_rise_cyc, fc + 4);
    checkOutput("level_one", {28'h0, level}, 32'h1);
    waitRefresh(snap, HOLD + 40, ok);
    checkOutput("refresh_seen", {31'h0, ok}, 32'h1);
    checkOutput("refresh_time", last_refresh_cyc, fc + HOLD + 6);
    @(posedge clk); #1 rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd_ready = 1'b0;
    checkOutput("level_after_pop", {28'h0, level}, 32'h0);
    repeat (HOLD + 30) @(posedge clk);
    checkOutput("single_refresh_only", refresh_cnt, snap + 1);

    // Non-matching port, INTACK and memory write produce nothing
    $display("[TB] ignored cycles");
    snap = refresh_cnt;
    applyStimulus(8'h20, 8'h11, 1'b0, 1'b1, 4, fc);
    applyStimulus(8'h13, 8'h22, 1'b0, 1'b0, 4, fc);
    applyStimulus(8'h14, 8'h33, 1'b1, 1'b1, 4, fc);
    repeat (HOLD + 30) @(posedge clk);
    checkOutput("ignored_level", {28'h0, level}, 32'h0);
    checkOutput("ignored_no_refresh", refresh_cnt, snap);

    // Nine writes with no consumer: full, overflow, head preserved, then drain in order
    $display("[TB] overflow");
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({8'h10 + 8'(i), 8'hC0 + 8'(i)});
      applyStimulus(8'h10 + 8'(i), 8'hC0 + 8'(i), 1'b0, 1'b1, 2, fc);
    end
    checkOutput("full_level", {28'h0, level}, 32'h8);
    checkOutput("overflow_set", {31'h0, overflow}, 32'h1);
    checkOutput("head_addr", {24'h0, rd_addr}, 32'h10);
    checkOutput("head_data", {24'h0, rd_data}, 32'hC0);
    @(posedge clk); #1 rd_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("drained_level", {28'h0, level}, 32'h0);
    checkOutput("overflow_sticky", {31'h0, overflow}, 32'h1);
    repeat (120) @(posedge clk);

    // Busy handshake: writes during busy yield exactly one follow-up refresh after busy falls
    $display("[TB] busy handshake");
    busy_model_en = 1'b1;
    snap = refresh_cnt;
    exp_q.push_back(16'h135A);
    applyStimulus(8'h13, 8'h5A, 1'b0, 1'b1, 3, fc);
    waitRefresh(snap, HOLD + 40, ok);
    checkOutput("busy_first_refresh", {31'h0, ok}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'h14 + 8'(i), 8'h60 + 8'(i)});
      applyStimulus(8'h14 + 8'(i), 8'h60 + 8'(i), 1'b0, 1'b1, 2, fc);
    end
    fall = -1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
    checkOutput("busy_fell", {31'h0, (fall >= 0)}, 32'h1);
    waitRefresh(snap + 1, HOLD + 40, ok);
    checkOutput("busy_second_refresh", {31'h0, ok}, 32'h1);
    checkOutput("second_after_busy", {31'h0, (last_refresh_cyc > fall)}, 32'h1);
    repeat (HOLD + 100) @(posedge clk);
    checkOutput("busy_refresh_count", refresh_cnt, snap + 2);
    busy_model_en = 1'b0;
    for (int i = 0; i < 80 && busy; i++) @(posedge clk);
    #1 busy = 1'b0;

    // Busy never rises: FSM times out back to IDLE and serves the next write normally
    $display("[TB] lost request");
    snap = refresh_cnt;
    exp_q.push_back(16'h1777);
    applyStimulus(8'h17, 8'h77, 1'b0, 1'b1, 3, fc);
    waitRefresh(snap, HOLD + 40, ok);
    checkOutput("lost_first_refresh", {31'h0, ok}, 32'h1);
    repeat (20) @(posedge clk);
    exp_q.push_back(16'h1888);
    applyStimulus(8'h18, 8'h88, 1'b0, 1'b1, 3, fc2);
    waitRefresh(snap + 1, HOLD + 40, ok);
    checkOutput("after_timeout_refresh", {31'h0, ok}, 32'h1);
    checkOutput("after_timeout_time", last_refresh_cyc, fc2 + HOLD + 6);
    repeat (10) @(posedge clk);

    // Reset with five entries queued discards everything
    $display("[TB] reset mid-traffic");
    #1 rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h11 + 8'(i), 8'h90 + 8'(i), 1'b0, 1'b1, 2, fc);
    checkOutput("pre_reset_level", {28'h0, level}, 32'h5);
    checkOutput("pre_reset_overflow", {31'h0, overflow}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_reset_level", {28'h0, level}, 32'h0);
    checkOutput("mid_reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    checkOutput("mid_reset_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    snap = refresh_cnt;
    repeat (HOLD + 30) @(posedge clk);
    checkOutput("post_reset_no_refresh", refresh_cnt, snap);
    checkOutput("post_reset_level", {28'h0, level}, 32'h0);

    checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
